acc_unit: RTL and testbench
===========================

// Module: acc_unit
// PURPOSE
//   Parametrised accumulator/register unit for the W-bus datapath; successor to the single 8-bit accumulator.
//   Holds NREGS registers (reg 0 = accumulator A, always driven to the adder/subtractor).
//   Adds in-place INC/DEC/CLR and multi-cycle shift/rotate with busy/done handshake and Z/S/C flags.
//   Bus output drives IDLE_VAL when not enabled, so the bus mux ignores this source.
// PARAMETERS
//   WIDTH     8                   data width of registers and bus
//   NREGS     2                   number of registers (>=1); reg 0 is accumulator A
//   IDLE_VAL  {WIDTH{1'b1}}       data_out value while Ea=0
//   SELW      $clog2(NREGS) (min 1)  register select width (localparam)
//   SHW       $clog2(WIDTH)+1        shift amount width (localparam)
// PORTS
//   CLK            in   1      clock, rising edge
//   CLR_bar        in   1      reset, asynchronous, active-low
//   La_bar         in   1      load regs[wr_sel] from data_in, active-low
//   Ea             in   1      enable regs[rd_sel] onto data_out
//   wr_sel         in   SELW   target register for load and ops
//   rd_sel         in   SELW   register driven on data_out
//   op_valid       in   1      op request, sampled on rising CLK
//   op             in   3      000 NOP,001 INC,010 DEC,011 CLR,100 SHL,101 SHR,110 ROL,111 ROR
//   shamt          in   SHW    shift/rotate amount, 0..WIDTH
//   data_in        in   WIDTH  W-bus input
//   data_out       out  WIDTH  Ea ? regs[rd_sel] : IDLE_VAL (combinational)
//   adder_sub_out  out  WIDTH  regs[0], always (combinational)
//   busy           out  1      multi-cycle shift in progress
//   done           out  1      one-cycle pulse: op completed
//   flag_z/s/c     out  1      zero / sign (MSB) / carry of last completed op
// BEHAVIOUR
//   Reset (CLR_bar=0, async): all regs 0, flags 0, busy 0, done 0, FSM IDLE; aborts any shift, no done.
//   Load: at edge with La_bar=0 and busy=0, regs[wr_sel]<=data_in; loads ignored while busy; flags unchanged.
//   Accept: op accepted at edge with op_valid=1, busy=0, La_bar=1; load wins over op, op dropped, no done.
//   op_valid while busy: ignored. wr_sel>=NREGS: load/op ignored, no done. rd_sel>=NREGS: data_out=0 if Ea.
//   NOP/INC/DEC/CLR: register and flags updated at accepting edge; done=1 in following cycle; busy stays 0.
//   INC/DEC modulo 2^WIDTH; C=carry out (INC max->0) / borrow (DEC 0->max). CLR: Z=1,S=0,C=0. NOP: flags kept.
//   Shifts, FSM IDLE->SHIFT->IDLE: shamt>WIDTH clamped to WIDTH; shamt=0 = single-cycle, value kept, C=0.
//   SHIFT: busy=1 from cycle after accept; one bit position per cycle; counter loaded with shamt at accept.
//   After shamt cycles reg holds final value, FSM->IDLE, busy=0 and done=1 same cycle; next op accepted there.
//   SHL/SHR logical, zero fill; C = last bit shifted out. ROL/ROR: C = last bit rotated across the end.
//   Z/S from final result, updated together with C on completion; intermediate values visible on data_out.
//   Flags apply to wr_sel register captured at accept; wr_sel changes during SHIFT have no effect.
// TESTING (WIDTH=8, NREGS=2)
//   Reset mid-SHL (shamt=5, cycle 2) -> regs 0, busy 0, done never pulses, data_out=FF with Ea=0.
//   Load 8'h7F into reg0, INC -> reg0=80, S=1,Z=0,C=0, done 1 cycle; INC from FF -> 00, Z=1,C=1.
//   Load 8'h81 reg1, ROR shamt=3 -> busy 3 cycles, reg1=8'h30 then done; C=0; adder_sub_out unchanged.
//   SHL shamt=9 on 8'hFF -> clamped to 8: 8 busy cycles, result 00, Z=1, C=1.
//   op_valid during busy and La_bar=0 during busy -> both ignored; La_bar=0 with op_valid (idle) -> load only.
//   Ea=0 -> data_out=FF; Ea=1,rd_sel=1 -> reg1; DEC reg0 from 00 -> FF, C=1, S=1.

Source files
------------

// File: rtl/acc_unit.sv
// Parametrised accumulator/register file for the W-bus datapath.
// Reg 0 feeds the adder/subtractor. In-place INC/DEC/CLR ops; multi-cycle shift/rotate with Z/S/C flags.
module acc_unit #(
    parameter int             WIDTH    = 8,
    parameter int             NREGS    = 2,
    parameter logic [WIDTH-1:0] IDLE_VAL = '1,
    localparam int            SELW     = (NREGS > 1) ? $clog2(NREGS) : 1,
    localparam int            SHW      = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             CLR_bar,
    input  logic             La_bar,
    input  logic             Ea,
    input  logic [SELW-1:0]  wr_sel,
    input  logic [SELW-1:0]  rd_sel,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] adder_sub_out,
    output logic             busy,
    output logic             done,
    output logic             flag_z,
    output logic             flag_s,
    output logic             flag_c
);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] regs [NREGS];
    logic [SHW-1:0]   cnt, shamt_c;
    logic [1:0]       sh_op;
    logic [SELW-1:0]  sh_sel;
    logic             wr_ok, rd_ok, load, accept, start_shift, last_step;
    logic [WIDTH-1:0] tgt, sh_cur, step_val;
    logic             step_c;
    logic [WIDTH:0]   inc_full, dec_full;

    always_comb begin
        wr_ok       = int'(wr_sel) < NREGS;
        rd_ok       = int'(rd_sel) < NREGS;
        load        = !La_bar && (state == S_IDLE) && wr_ok;
        accept      = op_valid && La_bar && (state == S_IDLE) && wr_ok;
        shamt_c     = (int'(shamt) > WIDTH) ? SHW'(WIDTH) : shamt;
        start_shift = accept && op[2] && (shamt_c != '0);
        last_step   = (state == S_SHIFT) && (cnt == SHW'(1));
        tgt         = wr_ok ? regs[wr_sel] : '0;
        sh_cur      = regs[sh_sel];
        inc_full    = {1'b0, tgt} + (WIDTH+1)'(1);
        dec_full    = {1'b0, tgt} - (WIDTH+1)'(1);
        busy        = (state == S_SHIFT);
        adder_sub_out = regs[0];
        data_out    = !Ea ? IDLE_VAL : (rd_ok ? regs[rd_sel] : '0);
    end

    // One bit position per cycle; step_c is the bit leaving (or crossing) the end.
    always_comb begin
        step_val = sh_cur;
        step_c   = 1'b0;
        case (sh_op)
            2'b00: begin step_val = {sh_cur[WIDTH-2:0], 1'b0};         step_c = sh_cur[WIDTH-1]; end
            2'b01: begin step_val = {1'b0, sh_cur[WIDTH-1:1]};         step_c = sh_cur[0];       end
            2'b10: begin step_val = {sh_cur[WIDTH-2:0], sh_cur[WIDTH-1]}; step_c = sh_cur[WIDTH-1]; end
            default: begin step_val = {sh_cur[0], sh_cur[WIDTH-1:1]};  step_c = sh_cur[0];       end
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start_shift) next_state = S_SHIFT;
            S_SHIFT: if (last_step)   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) state <= S_IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            regs   <= '{default: '0};
            cnt    <= '0;
            sh_op  <= '0;
            sh_sel <= '0;
            done   <= 1'b0;
            flag_z <= 1'b0;
            flag_s <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                regs[wr_sel] <= data_in;
            end else if (accept) begin
                done <= !start_shift;
                case (op)
                    3'b000: ;
                    3'b001: begin
                        regs[wr_sel] <= inc_full[WIDTH-1:0];
                        flag_z <= (inc_full[WIDTH-1:0] == '0);
                        flag_s <= inc_full[WIDTH-1];
                        flag_c <= inc_full[WIDTH];
                    end
                    3'b010: begin
                        regs[wr_sel] <= dec_full[WIDTH-1:0];
                        flag_z <= (dec_full[WIDTH-1:0] == '0);
                        flag_s <= dec_full[WIDTH-1];
                        flag_c <= dec_full[WIDTH];
                    end
                    3'b011: begin
                        regs[wr_sel] <= '0;
                        flag_z <= 1'b1;
                        flag_s <= 1'b0;
                        flag_c <= 1'b0;
                    end
                    default: begin
                        if (shamt_c == '0) begin
                            flag_z <= (tgt == '0);
                            flag_s <= tgt[WIDTH-1];
                            flag_c <= 1'b0;
                        end else begin
                            sh_sel <= wr_sel;
                            sh_op  <= op[1:0];
                            cnt    <= shamt_c;
                        end
                    end
                endcase
            end else if (state == S_SHIFT) begin
                regs[sh_sel] <= step_val;
                cnt          <= cnt - SHW'(1);
                if (last_step) begin
                    flag_z <= (step_val == '0);
                    flag_s <= step_val[WIDTH-1];
                    flag_c <= step_c;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_unit.sv
// Directed bench for acc_unit (WIDTH=8, NREGS=2) with a scoreboard of expected op results.
module tb_acc_unit;

    logic       CLK = 1'b0, CLR_bar = 1'b0, La_bar = 1'b1, Ea = 1'b0, op_valid = 1'b0;
    logic       wr_sel = 1'b0, rd_sel = 1'b0;
    logic [2:0] op = 3'b000;
    logic [3:0] shamt = 4'd0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out, adder_sub_out;
    logic       busy, done, flag_z, flag_s, flag_c;

    acc_unit #(.WIDTH(8), .NREGS(2), .IDLE_VAL(8'hFF)) dut (
        .CLK(CLK), .CLR_bar(CLR_bar), .La_bar(La_bar), .Ea(Ea),
        .wr_sel(wr_sel), .rd_sel(rd_sel), .op_valid(op_valid), .op(op),
        .shamt(shamt), .data_in(data_in), .data_out(data_out),
        .adder_sub_out(adder_sub_out), .busy(busy), .done(done),
        .flag_z(flag_z), .flag_s(flag_s), .flag_c(flag_c)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] val;
        logic       z, s, c;
        int         sel;
        int         nbusy;
    } exp_t;

    exp_t       sb[$];
    int         n_pass = 0, n_total = 0, n_fail = 0;
    logic [7:0] m [2];
    logic       mz = 1'b0, ms = 1'b0, mc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_reg(input int sel, input logic [7:0] v);
        @(negedge CLK);
        La_bar = 1'b0; wr_sel = sel[0]; data_in = v;
        @(negedge CLK);
        La_bar = 1'b1;
        m[sel] = v;
    endtask

    // Reference result computed from whole-word arithmetic, not bit stepping.
    task automatic model(input logic [2:0] o, input int sel, input int n_in, output exp_t e);
        logic [7:0]  v;
        logic [15:0] w;
        int          n;
        v = m[sel];
        n = (n_in > 8) ? 8 : n_in;
        e.sel = sel; e.nbusy = 0; e.val = v; e.z = mz; e.s = ms; e.c = mc;
        case (o)
            3'd0: ;
            3'd1: begin e.val = v + 8'd1; e.c = (v == 8'hFF); end
            3'd2: begin e.val = v - 8'd1; e.c = (v == 8'h00); end
            3'd3: begin e.val = 8'h00;    e.c = 1'b0; end
            default: begin
                if (n == 0) e.c = 1'b0;
                else begin
                    e.nbusy = n;
                    case (o)
                        3'd4: begin w = {8'h00, v} << n; e.val = w[7:0];  e.c = v[8-n]; end
                        3'd5: begin e.val = v >> n;                      e.c = v[n-1]; end
                        3'd6: begin w = {v, v} << n;      e.val = w[15:8]; e.c = v[8-n]; end
                        default: begin w = {v, v} >> n;   e.val = w[7:0];  e.c = v[n-1]; end
                    endcase
                end
            end
        endcase
        if (o != 3'd0) begin e.z = (e.val == 8'h00); e.s = e.val[7]; end
        m[sel] = e.val; mz = e.z; ms = e.s; mc = e.c;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input int sel, input int n,
                          input bit meddle);
        exp_t e, got;
        int   guard, bc;
        model(o, sel, n, e);
        sb.push_back(e);
        @(negedge CLK);
        op_valid = 1'b1; op = o; wr_sel = sel[0]; shamt = n[3:0]; La_bar = 1'b1;
        @(negedge CLK);
        op_valid = 1'b0;
        guard = 0; bc = 0;
        while (done !== 1'b1 && guard < 40) begin
            if (busy === 1'b1) bc++;
            if (meddle && bc == 1) begin
                op_valid = 1'b1; op = 3'b001; wr_sel = ~sel[0]; La_bar = 1'b0; data_in = 8'hAA;
            end else begin
                op_valid = 1'b0; La_bar = 1'b1; wr_sel = sel[0];
            end
            @(negedge CLK);
            guard++;
        end
        op_valid = 1'b0; La_bar = 1'b1;
        chk($sformatf("%s_timeout", tag), guard < 40, 1);
        got = sb.pop_front();
        chk($sformatf("%s_busy_cycles", tag), bc, got.nbusy);
        chk($sformatf("%s_busy_at_done", tag), busy, 0);
        chk($sformatf("%s_flags_zsc", tag), {flag_z, flag_s, flag_c}, {got.z, got.s, got.c});
        Ea = 1'b1; rd_sel = got.sel[0];
        #1;
        chk($sformatf("%s_value", tag), data_out, got.val);
        Ea = 1'b0;
        @(negedge CLK);
        chk($sformatf("%s_done_pulse", tag), done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       seen;
        logic [7:0] a0;
        m[0] = 8'h00; m[1] = 8'h00;

        repeat (2) @(negedge CLK);
        chk("rst_data_out", data_out, 8'hFF);
        chk("rst_acc", adder_sub_out, 8'h00);
        chk("rst_busy_done", {busy, done}, 2'b00);
        chk("rst_flags", {flag_z, flag_s, flag_c}, 3'b000);
        CLR_bar = 1'b1;

        // reset in the middle of a 5-bit SHL
        load_reg(0, 8'hFF);
        @(negedge CLK);
        op_valid = 1'b1; op = 3'd4; wr_sel = 1'b0; shamt = 4'd5;
        @(negedge CLK);
        op_valid = 1'b0;
        chk("midrst_busy_c1", busy, 1);
        @(negedge CLK);
        chk("midrst_intermediate", adder_sub_out, 8'hFE);
        #2 CLR_bar = 1'b0;
        #1;
        chk("midrst_acc", adder_sub_out, 8'h00);
        chk("midrst_busy", busy, 0);
        chk("midrst_data_out", data_out, 8'hFF);
        @(negedge CLK);
        CLR_bar = 1'b1;
        m[0] = 8'h00; m[1] = 8'h00; mz = 1'b0; ms = 1'b0; mc = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        chk("midrst_no_done", seen, 0);

        load_reg(0, 8'h7F);
        run_op("inc_7f", 3'd1, 0, 0, 1'b0);
        load_reg(0, 8'hFF);
        run_op("inc_ff", 3'd1, 0, 0, 1'b0);

        load_reg(1, 8'h81);
        a0 = m[0];
        run_op("ror3", 3'd7, 1, 3, 1'b0);
        chk("ror3_acc_unchanged", adder_sub_out, a0);

        load_reg(1, 8'hFF);
        run_op("shl9", 3'd4, 1, 9, 1'b0);

        load_reg(1, 8'hF8);
        run_op("shr4_ignored_req", 3'd5, 1, 4, 1'b1);
        chk("shr4_reg0_untouched", adder_sub_out, m[0]);

        // load and op in the same idle cycle: only the load happens
        @(negedge CLK);
        La_bar = 1'b0; op_valid = 1'b1; op = 3'd1; wr_sel = 1'b0; data_in = 8'h42;
        @(negedge CLK);
        La_bar = 1'b1; op_valid = 1'b0;
        m[0] = 8'h42;
        chk("loadwins_done", done, 0);
        chk("loadwins_value", adder_sub_out, 8'h42);
        chk("loadwins_flags", {flag_z, flag_s, flag_c}, {mz, ms, mc});
        @(negedge CLK);
        chk("loadwins_no_late_done", {done, busy}, 2'b00);

        run_op("rol2", 3'd6, 1, 2, 1'b0);
        run_op("ror0", 3'd7, 0, 0, 1'b0);
        run_op("nop", 3'd0, 1, 0, 1'b0);

        Ea = 1'b0; #1;
        chk("ea0_idle", data_out, 8'hFF);
        Ea = 1'b1; rd_sel = 1'b1; #1;
        chk("ea1_rd1", data_out, m[1]);
        rd_sel = 1'b0; #1;
        chk("ea1_rd0", data_out, m[0]);
        Ea = 1'b0;

        run_op("clr", 3'd3, 0, 0, 1'b0);
        run_op("dec_00", 3'd2, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
